// File: rtl/hysteresis_stream_if.sv
// Valid/ready bundle for hysteresis_stream: magnitude input stream and edge-map output stream.
// The slave modport is the hysteresis stage itself; master is the surrounding pipeline.
interface hysteresis_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pix;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pix;
  logic              out_last;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );
endinterface

// File: rtl/hysteresis_stream.sv
// Streaming Canny hysteresis: classifies magnitudes, promotes weak pixels touching a strong one.
// Optional feature macro HYSTERESIS_STATS_EN adds promoted/suppressed weak-pixel counters.
module hysteresis_stream #(
  parameter int         DATA_W     = 8,
  parameter int         IMG_W      = 16,
  parameter int         IMG_H      = 16,
  parameter logic [7:0] EDGE_PIXEL = 8'd255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] thr_low,
  input  logic [DATA_W-1:0] thr_high,
  output logic              busy,
  output logic              done,
`ifdef HYSTERESIS_STATS_EN
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] promoted_count,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] suppressed_count,
`endif
  hysteresis_stream_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] PIX_ALL  = CNT_W'(NPIX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_WEAK = 2'd1, CLS_STRONG = 2'd2} cls_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] thr_low_q, thr_high_q;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  logic [COL_W-1:0]  lb_col, cen_col;
  logic [ROW_W-1:0]  cen_row;
  cls_t              lb_a [IMG_W];
  cls_t              lb_b [IMG_W];
  cls_t              win_l [3];
  cls_t              win_m [3];
  cls_t              in_cls, push_cls, up_cls, mid_cls;
  logic              out_free, start_ok, push, emit;
  logic              border, nbr_strong, is_edge;

  assign out_free = bus.out_ready || !bus.out_valid;
  assign busy     = (state == S_FILL) || (state == S_STREAM) || (state == S_FLUSH);
  assign done     = (state == S_DONE);

  // The incoming pixel plus the two line-buffer reads form the right-hand window column.
  always_comb begin
    in_cls = CLS_NONE;
    if (bus.in_pix >= thr_high_q) begin
      in_cls = CLS_STRONG;
    end else if (bus.in_pix >= thr_low_q) begin
      in_cls = CLS_WEAK;
    end
    push_cls = (state == S_FLUSH) ? CLS_NONE : in_cls;
    up_cls   = lb_b[lb_col];
    mid_cls  = lb_a[lb_col];
  end

  always_comb begin
    border = (cen_row == '0) || (cen_row == ROW_LAST) ||
             (cen_col == '0) || (cen_col == COL_LAST);
    nbr_strong = (win_l[0] == CLS_STRONG) || (win_l[1] == CLS_STRONG) ||
                 (win_l[2] == CLS_STRONG) || (win_m[0] == CLS_STRONG) ||
                 (win_m[2] == CLS_STRONG) || (up_cls == CLS_STRONG) ||
                 (mid_cls == CLS_STRONG) || (push_cls == CLS_STRONG);
    is_edge = (win_m[1] == CLS_STRONG) ||
              ((win_m[1] == CLS_WEAK) && !border && nbr_strong);
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    start_ok     = 1'b0;
    push         = 1'b0;
    emit         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          push = 1'b1;
          if (in_cnt == FILL_END) state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        bus.in_ready = out_free;
        if (bus.in_valid && out_free) begin
          push = 1'b1;
          emit = 1'b1;
          if (in_cnt == PIX_LAST) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((out_cnt != PIX_ALL) && out_free) begin
          push = 1'b1;
          emit = 1'b1;
        end
        if (bus.out_valid && bus.out_ready && bus.out_last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_low_q  <= '0;
      thr_high_q <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      lb_col     <= '0;
      cen_row    <= '0;
      cen_col    <= '0;
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= CLS_NONE;
        win_m[i] <= CLS_NONE;
      end
    end else begin
      if (start_ok) begin
        thr_low_q  <= thr_low;
        thr_high_q <= thr_high;
        in_cnt     <= '0;
        out_cnt    <= '0;
        lb_col     <= '0;
        cen_row    <= '0;
        cen_col    <= '0;
      end
      if (push) begin
        lb_col <= (lb_col == COL_LAST) ? '0 : lb_col + 1'b1;
        if (state != S_FLUSH) in_cnt <= in_cnt + 1'b1;
        for (int i = 0; i < 3; i++) win_l[i] <= win_m[i];
        win_m[0] <= up_cls;
        win_m[1] <= mid_cls;
        win_m[2] <= push_cls;
      end
      if (emit) begin
        out_cnt <= out_cnt + 1'b1;
        if (cen_col == COL_LAST) begin
          cen_col <= '0;
          cen_row <= (cen_row == ROW_LAST) ? '0 : cen_row + 1'b1;
        end else begin
          cen_col <= cen_col + 1'b1;
        end
      end
    end
  end

  // Line buffers need no reset: FILL rewrites every slot before a non-border centre reads it.
  always_ff @(posedge clk) begin
    if (push) begin
      lb_a[lb_col] <= push_cls;
      lb_b[lb_col] <= mid_cls;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_pix   <= '0;
      bus.out_last  <= 1'b0;
    end else if (emit) begin
      bus.out_valid <= 1'b1;
      bus.out_pix   <= is_edge ? EDGE_PIXEL : 8'd0;
      bus.out_last  <= (out_cnt == PIX_LAST);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

`ifdef HYSTERESIS_STATS_EN
  logic out_weak, out_prom;

  // Counts are taken when the beat is handed off, so stalls never double-count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_weak         <= 1'b0;
      out_prom         <= 1'b0;
      promoted_count   <= '0;
      suppressed_count <= '0;
    end else begin
      if (emit) begin
        out_weak <= (win_m[1] == CLS_WEAK);
        out_prom <= is_edge;
      end
      if (start_ok) begin
        promoted_count   <= '0;
        suppressed_count <= '0;
      end else if (bus.out_valid && bus.out_ready && out_weak) begin
        if (out_prom) promoted_count   <= promoted_count + 1'b1;
        else          suppressed_count <= suppressed_count + 1'b1;
      end
    end
  end
`endif

endmodule
